fft_peak_detect: RTL

- Consumes the Avalon-ST output stream of the FFT megacore: source_real/imag, sop/eop, valid and block exponent.
- Computes a per-bin magnitude and tracks the strongest bin in the positive-frequency half of each frame.
- Reports that bin, its magnitude and the frame exponent once per frame; the note-decision logic uses the result.
- Downstream counterpart of the FFT sink-side framing stage.

---
 rtl/fft_peak_pkg.sv | 15 +
 rtl/fft_peak_if.sv | 33 +++
 rtl/fft_mag_calc.sv | 100 ++++++++++
 rtl/fft_peak_detect.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fft_peak_pkg.sv
// rtl/fft_peak_pkg.sv - shared widths, defaults and state type for the FFT peak detector
package fft_peak_pkg;

   localparam int DEF_FFT_LEN = 8192;
   localparam int DEF_BIN_W   = 13;
   localparam int DEF_DATA_W  = 16;
   localparam int EXP_W       = 6;

   typedef enum logic {IDLE, FRAME} state_t;

   function automatic int mag_w(input int data_w);
      return 2 * data_w + 1;
   endfunction

endpackage

// File: rtl/fft_peak_if.sv
// rtl/fft_peak_if.sv - FFT source stream and peak result bundle
interface fft_peak_if #(
   parameter int DATA_W = fft_peak_pkg::DEF_DATA_W,
   parameter int BIN_W  = fft_peak_pkg::DEF_BIN_W
);
   localparam int MAG_W = fft_peak_pkg::mag_w(DATA_W);
   localparam int EXP_W = fft_peak_pkg::EXP_W;

   logic                     source_valid;
   logic                     source_ready;
   logic                     source_sop;
   logic                     source_eop;
   logic signed [DATA_W-1:0] source_real;
   logic signed [DATA_W-1:0] source_imag;
   logic signed [EXP_W-1:0]  source_exp;
   logic                     peak_valid;
   logic                     peak_found;
   logic [BIN_W-1:0]         peak_bin;
   logic [MAG_W-1:0]         peak_mag;
   logic [EXP_W-1:0]         peak_exp;
   logic                     frame_err;

   modport master (
      output source_valid, source_sop, source_eop, source_real, source_imag, source_exp,
      input  source_ready, peak_valid, peak_found, peak_bin, peak_mag, peak_exp, frame_err
   );

   modport slave (
      input  source_valid, source_sop, source_eop, source_real, source_imag, source_exp,
      output source_ready, peak_valid, peak_found, peak_bin, peak_mag, peak_exp, frame_err
   );

endinterface

// File: rtl/fft_mag_calc.sv
// rtl/fft_mag_calc.sv - two-stage bin magnitude pipeline; FFT_PEAK_MAG_APPROX_EN selects alpha-max-beta-min
module fft_mag_calc
   import fft_peak_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int BIN_W  = DEF_BIN_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_real,
   input  logic signed [DATA_W-1:0] in_imag,
   input  logic [BIN_W-1:0]         in_bin,
   input  logic                     in_elig,
   input  logic                     in_last,
   output logic                     out_valid,
   output logic [2*DATA_W:0]        out_mag,
   output logic [BIN_W-1:0]         out_bin,
   output logic                     out_elig,
   output logic                     out_last
);
   localparam int SQ_W  = 2 * DATA_W;
   localparam int MAG_W = mag_w(DATA_W);

   logic             s1_valid, s1_elig, s1_last;
   logic [BIN_W-1:0] s1_bin;
   logic [SQ_W-1:0]  s1_a, s1_b, a_nx, b_nx;
   logic [MAG_W-1:0] mag_nx;

`ifdef FFT_PEAK_MAG_APPROX_EN
   // The most negative input has no positive twin, so clamp it.
   function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] v);
      if (v == {1'b1, {(DATA_W-1){1'b0}}})
         return {1'b0, {(DATA_W-1){1'b1}}};
      else if (v[DATA_W-1])
         return -v;
      else
         return v;
   endfunction

   logic [SQ_W-1:0] hi, lo;

   always_comb begin
      a_nx = {{DATA_W{1'b0}}, abs_sat(in_real)};
      b_nx = {{DATA_W{1'b0}}, abs_sat(in_imag)};
   end

   always_comb begin
      hi = s1_a;
      lo = s1_b;
      if (s1_b > s1_a) begin
         hi = s1_b;
         lo = s1_a;
      end
      mag_nx = MAG_W'(hi + (lo >> 1));
   end
`else
   logic signed [SQ_W-1:0] sq_re, sq_im;

   always_comb begin
      sq_re = SQ_W'(in_real) * SQ_W'(in_real);
      sq_im = SQ_W'(in_imag) * SQ_W'(in_imag);
      a_nx  = $unsigned(sq_re);
      b_nx  = $unsigned(sq_im);
   end

   always_comb begin
      mag_nx = {1'b0, s1_a} + {1'b0, s1_b};
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_elig   <= 1'b0;
         s1_last   <= 1'b0;
         s1_bin    <= '0;
         s1_a      <= '0;
         s1_b      <= '0;
         out_valid <= 1'b0;
         out_elig  <= 1'b0;
         out_last  <= 1'b0;
         out_bin   <= '0;
         out_mag   <= '0;
      end else begin
         s1_valid  <= in_valid;
         s1_elig   <= in_elig;
         s1_last   <= in_last;
         s1_bin    <= in_bin;
         s1_a      <= a_nx;
         s1_b      <= b_nx;
         out_valid <= s1_valid;
         out_elig  <= s1_elig;
         out_last  <= s1_last;
         out_bin   <= s1_bin;
         out_mag   <= mag_nx;
      end
   end

endmodule

// File: rtl/fft_peak_detect.sv
// rtl/fft_peak_detect.sv - frames the FFT output stream and reports the strongest positive-frequency bin
// Magnitude mode follows FFT_PEAK_MAG_APPROX_EN inside fft_mag_calc.
module fft_peak_detect
   import fft_peak_pkg::*;
#(
   parameter int     FFT_LEN    = DEF_FFT_LEN,
   parameter int     BIN_W      = DEF_BIN_W,
   parameter int     DATA_W     = DEF_DATA_W,
   parameter int     MIN_BIN    = 1,
   parameter longint MAG_THRESH = 0
) (
   input logic       clk,
   input logic       reset,
   fft_peak_if.slave bus
);
   localparam int               MAG_W     = mag_w(DATA_W);
   localparam logic [BIN_W-1:0] LAST_BIN  = BIN_W'(FFT_LEN - 1);
   localparam logic [BIN_W-1:0] HALF_LAST = BIN_W'(FFT_LEN / 2 - 1);
   localparam logic [BIN_W-1:0] MIN_B     = BIN_W'(MIN_BIN);
   localparam logic [MAG_W-1:0] THRESH    = MAG_W'(MAG_THRESH);

   state_t           state, state_nx;
   logic [BIN_W-1:0] bin_cnt, bin_cnt_nx, push_bin;
   logic             ready_q, beat, push, push_elig, push_last, err_nx;
   logic [EXP_W-1:0] exp_q;

   logic             m_valid, m_elig, m_last;
   logic [BIN_W-1:0] m_bin, max_bin, base_bin;
   logic [MAG_W-1:0] m_mag, max_mag, base_mag;
   logic [MAG_W:0]   thr_diff;
   logic             done_q, found;

   assign bus.source_ready = ready_q;
   assign beat             = bus.source_valid && ready_q;
   assign push_elig        = (push_bin >= MIN_B) && (push_bin <= HALF_LAST);

   // bin_cnt holds the index of the beat currently being accepted.
   always_comb begin
      state_nx   = state;
      bin_cnt_nx = bin_cnt;
      push       = 1'b0;
      push_bin   = bin_cnt;
      push_last  = 1'b0;
      err_nx     = 1'b0;
      if (beat) begin
         unique case (state)
            IDLE: begin
               if (bus.source_sop) begin
                  push     = 1'b1;
                  push_bin = '0;
                  if (bus.source_eop) begin
                     err_nx = 1'b1;
                  end else begin
                     state_nx   = FRAME;
                     bin_cnt_nx = BIN_W'(1);
                  end
               end
            end
            FRAME: begin
               push = 1'b1;
               if (bus.source_sop && bus.source_eop) begin
                  push_bin = '0;
                  err_nx   = 1'b1;
                  state_nx = IDLE;
               end else if (bus.source_sop) begin
                  push_bin   = '0;
                  err_nx     = 1'b1;
                  bin_cnt_nx = BIN_W'(1);
               end else if (bus.source_eop) begin
                  state_nx = IDLE;
                  if (bin_cnt == LAST_BIN)
                     push_last = 1'b1;
                  else
                     err_nx = 1'b1;
               end else if (bin_cnt == LAST_BIN) begin
                  err_nx   = 1'b1;
                  state_nx = IDLE;
               end else begin
                  bin_cnt_nx = bin_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         bin_cnt       <= '0;
         ready_q       <= 1'b0;
         exp_q         <= '0;
         bus.frame_err <= 1'b0;
      end else begin
         state         <= state_nx;
         bin_cnt       <= bin_cnt_nx;
         ready_q       <= 1'b1;
         bus.frame_err <= err_nx;
         if (push_last)
            exp_q <= bus.source_exp;
      end
   end

   fft_mag_calc #(.DATA_W(DATA_W), .BIN_W(BIN_W)) u_mag (
      .clk      (clk),
      .reset    (reset),
      .in_valid (push),
      .in_real  (bus.source_real),
      .in_imag  (bus.source_imag),
      .in_bin   (push_bin),
      .in_elig  (push_elig),
      .in_last  (push_last),
      .out_valid(m_valid),
      .out_mag  (m_mag),
      .out_bin  (m_bin),
      .out_elig (m_elig),
      .out_last (m_last)
   );

   // Every frame starts at bin 0, so bin 0 reaching the tracker marks a frame boundary.
   always_comb begin
      base_mag = max_mag;
      base_bin = max_bin;
      if (m_bin == '0) begin
         base_mag = '0;
         base_bin = MIN_B;
      end
      thr_diff = {1'b0, max_mag} - {1'b0, THRESH};
      found    = (max_mag != '0) && !thr_diff[MAG_W];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         max_mag        <= '0;
         max_bin        <= MIN_B;
         done_q         <= 1'b0;
         bus.peak_valid <= 1'b0;
         bus.peak_found <= 1'b0;
         bus.peak_bin   <= '0;
         bus.peak_mag   <= '0;
         bus.peak_exp   <= '0;
      end else begin
         done_q         <= m_valid && m_last;
         bus.peak_valid <= done_q;
         if (m_valid) begin
            if (m_elig && (m_mag > base_mag)) begin
               max_mag <= m_mag;
               max_bin <= m_bin;
            end else begin
               max_mag <= base_mag;
               max_bin <= base_bin;
            end
         end
         if (done_q) begin
            bus.peak_found <= found;
            bus.peak_bin   <= found ? max_bin : '0;
            bus.peak_mag   <= found ? max_mag : '0;
            bus.peak_exp   <= exp_q;
         end
      end
   end

endmodule
